// File: rtl/distance_text_buffer_pkg.sv
// Shared constants for the distance-text feeder: ASCII codes, row-0 label, FSM states.
package distance_text_buffer_pkg;

  localparam int unsigned DIST_W_DEF     = 16;
  localparam int unsigned NUM_DIGITS_DEF = 5;
  localparam int unsigned LINE_CHARS_DEF = 30;
  localparam int unsigned DIGIT_COL_DEF  = 10;

  localparam logic [6:0] SPACE = 7'h20;
  localparam logic [6:0] ZERO  = 7'h30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FORMAT,
    ST_COMMIT
  } state_t;

  // Fixed text of row 0 around the digit field: "DISTANCE: " ... " CM".
  function automatic logic [6:0] label_char(input logic [4:0] col);
    logic [6:0] ch;
    case (col)
      5'd0:    ch = 7'h44; // D
      5'd1:    ch = 7'h49; // I
      5'd2:    ch = 7'h53; // S
      5'd3:    ch = 7'h54; // T
      5'd4:    ch = 7'h41; // A
      5'd5:    ch = 7'h4E; // N
      5'd6:    ch = 7'h43; // C
      5'd7:    ch = 7'h45; // E
      5'd8:    ch = 7'h3A; // :
      5'd16:   ch = 7'h43; // C
      5'd17:   ch = 7'h4D; // M
      default: ch = SPACE;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/distance_text_buffer_if.sv
// Sample/readout bus between the distance source, the overlay stage and the text buffer.
interface distance_text_buffer_if #(
  parameter int unsigned DIST_W = 16
);
  logic [DIST_W-1:0] distance;
  logic              distance_valid;
  logic              vblnk_in;
  logic [7:0]        char_xy;
  logic [6:0]        char_code;
  logic              busy;
  logic              update_done;

  modport master (
    output distance, distance_valid, vblnk_in, char_xy,
    input  char_code, busy, update_done
  );

  modport slave (
    input  distance, distance_valid, vblnk_in, char_xy,
    output char_code, busy, update_done
  );
endinterface

// File: rtl/distance_text_buffer_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, DIST_W iterations.
module bin2bcd_seq #(
  parameter int unsigned DIST_W     = 16,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIST_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned SR_W  = DIST_W + BCD_W;
  localparam int unsigned CNT_W = $clog2(DIST_W + 1);

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt;
  logic             active;

  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sr[DIST_W + 4*i +: 4] >= 4'd5)
        sr_adj[DIST_W + 4*i +: 4] = sr[DIST_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sr     <= SR_W'(bin);
      cnt    <= CNT_W'(DIST_W);
      active <= 1'b1;
    end else if (active) begin
      sr  <= {sr_adj[SR_W-2:0], 1'b0};
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1))
        active <= 1'b0;
    end
  end

  // done marks the cycle whose clock edge performs the final iteration,
  // so the caller can step to its next state on that same edge.
  assign busy = active;
  assign done = active && (cnt == CNT_W'(1));
  assign bcd  = sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/distance_text_buffer.sv
// Holds the "DISTANCE: ddddd CM" text line; new digits are committed only during vblank.
module distance_text_buffer
  import distance_text_buffer_pkg::*;
#(
  parameter int unsigned DIST_W     = DIST_W_DEF,
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned LINE_CHARS = LINE_CHARS_DEF,
  parameter int unsigned DIGIT_COL  = DIGIT_COL_DEF
) (
  input  logic                   pclk,
  input  logic                   rst,
  distance_text_buffer_if.slave  bus
);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0][6:0] DIGITS_RST = {{(NUM_DIGITS-1){SPACE}}, ZERO};

  state_t                   state, state_nx;
  logic                     pending;
  logic [DIST_W-1:0]        pend_val;
  logic                     eng_start, eng_busy, eng_done;
  logic [DIST_W-1:0]        eng_bin;
  logic [BCD_W-1:0]         eng_bcd;
  logic                     do_format, do_commit;
  logic [NUM_DIGITS-1:0][6:0] fmt, shadow, display;
  logic                     lead;
  logic [3:0]               nib;
  logic [6:0]               text_ch;
  logic [31:0]              col_i;
  logic [6:0]               char_code_q;
  logic                     update_done_q;

  bin2bcd_seq #(
    .DIST_W     (DIST_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .pclk  (pclk),
    .rst   (rst),
    .start (eng_start),
    .bin   (eng_bin),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_ff @(posedge pclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (pending || bus.distance_valid) state_nx = ST_SHIFT;
      ST_SHIFT:  if (eng_done) state_nx = ST_FORMAT;
      ST_FORMAT: state_nx = ST_COMMIT;
      ST_COMMIT: if (bus.vblnk_in) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_start = 1'b0;
    eng_bin   = pending ? pend_val : bus.distance;
    do_format = 1'b0;
    do_commit = 1'b0;
    case (state)
      ST_IDLE:   eng_start = pending || bus.distance_valid;
      ST_FORMAT: do_format = 1'b1;
      ST_COMMIT: do_commit = bus.vblnk_in;
      default:   ;
    endcase
  end

  // A strobe landing while busy, or while pending is being serviced, becomes the new pending sample.
  always_ff @(posedge pclk) begin
    if (rst) begin
      pending  <= 1'b0;
      pend_val <= '0;
    end else if (bus.distance_valid && (state != ST_IDLE || pending)) begin
      pending  <= 1'b1;
      pend_val <= bus.distance;
    end else if (state == ST_IDLE && pending) begin
      pending  <= 1'b0;
    end
  end

  always_comb begin
    lead = 1'b1;
    nib  = '0;
    fmt  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib = eng_bcd[4*(NUM_DIGITS-1-i) +: 4];
      if (lead && nib == 4'd0 && i != NUM_DIGITS-1) begin
        fmt[NUM_DIGITS-1-i] = SPACE;
      end else begin
        lead = 1'b0;
        fmt[NUM_DIGITS-1-i] = ZERO + 7'(nib);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      shadow        <= DIGITS_RST;
      display       <= DIGITS_RST;
      update_done_q <= 1'b0;
    end else begin
      update_done_q <= do_commit;
      if (do_format) shadow  <= fmt;
      if (do_commit) display <= shadow;
    end
  end

  always_comb begin
    col_i   = {27'd0, bus.char_xy[4:0]};
    text_ch = SPACE;
    if (bus.char_xy[7:5] == 3'd0 && col_i < LINE_CHARS) begin
      text_ch = label_char(bus.char_xy[4:0]);
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (col_i == DIGIT_COL + k)
          text_ch = display[NUM_DIGITS-1-k];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) char_code_q <= SPACE;
    else     char_code_q <= text_ch;
  end

  assign bus.char_code   = char_code_q;
  assign bus.update_done = update_done_q;
  assign bus.busy        = (state != ST_IDLE) || eng_busy;

endmodule
